// File: rtl/pwm_timer_core.sv
// PWM / timer counting stage: synchronises the divided slow_clk, counts its rising edges against period/duty.
// Optional PWM_SHADOW_REG_EN: period/duty are shadowed and only reloaded at IDLE->RUN and at each wrapping expiry.
module pwm_timer_core #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst_n,
    input  logic             slow_clk,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_cont,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_duty,
    input  logic             i_irq_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_pwm,
    output logic             o_irq,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             hist_q;
    logic             tick;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             pwm_q, pwm_nxt;
    logic             irq_q, irq_nxt;
    logic [CNT_W-1:0] period_act, duty_act;
    logic [CNT_W-1:0] period_nxt, duty_nxt;
    logic             expiry, wrap;

    function automatic logic pwm_level(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] period,
                                       input logic [CNT_W-1:0] duty);
        return (period != '0) && (cnt < duty);
    endfunction

    // slow_clk synchroniser and rising-edge detect
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick   = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign expiry = i_en && (state == RUN) && tick && (period_act != '0) &&
                    (cnt_q >= period_act - CNT_W'(1));
    assign wrap   = expiry && (i_mode || i_cont);

`ifdef PWM_SHADOW_REG_EN
    logic [CNT_W-1:0] period_sh, duty_sh;
    logic             load_act;

    assign load_act = ((state == IDLE) && i_en) || wrap;

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            period_sh <= '0;
            duty_sh   <= '0;
        end else if (load_act) begin
            period_sh <= i_period;
            duty_sh   <= i_duty;
        end
    end

    assign period_act = period_sh;
    assign duty_act   = duty_sh;
    assign period_nxt = load_act ? i_period : period_sh;
    assign duty_nxt   = load_act ? i_duty   : duty_sh;
`else
    assign period_act = i_period;
    assign duty_act   = i_duty;
    assign period_nxt = i_period;
    assign duty_nxt   = i_duty;
`endif

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state <= IDLE;
            cnt_q <= '0;
            pwm_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            pwm_q <= pwm_nxt;
            irq_q <= irq_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        pwm_nxt   = pwm_q;
        irq_nxt   = irq_q;

        // Set beats clear when both land on the same edge
        if (i_irq_clr) irq_nxt = 1'b0;
        if (expiry)    irq_nxt = 1'b1;

        if (!i_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pwm_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    pwm_nxt   = i_mode && pwm_level('0, period_nxt, duty_nxt);
                end
                RUN: begin
                    if (expiry) begin
                        if (wrap) cnt_nxt = '0;
                        else      state_nxt = DONE;
                        if (!i_mode) pwm_nxt = ~pwm_q;
                    end else if (period_act == '0) begin
                        cnt_nxt = '0;
                    end else if (tick) begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                    if (i_mode) pwm_nxt = pwm_level(cnt_nxt, period_nxt, duty_nxt);
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign o_cnt  = cnt_q;
    assign o_pwm  = pwm_q;
    assign o_irq  = irq_q;
    assign o_busy = (state == RUN);

endmodule

// File: tb/tb_pwm_timer_core.sv
// Scoreboard bench for pwm_timer_core: a per-tick reference model queues each expected output change,
// and a monitor pops and compares whenever the DUT outputs change.
module tb_pwm_timer_core;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 16;

    typedef logic [CNT_W+2:0] obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             slow_clk = 1'b0;
    logic             i_en = 1'b0;
    logic             i_mode = 1'b0;
    logic             i_cont = 1'b0;
    logic [CNT_W-1:0] i_period = '0;
    logic [CNT_W-1:0] i_duty = '0;
    logic             i_irq_clr = 1'b0;
    logic [CNT_W-1:0] o_cnt;
    logic             o_pwm, o_irq, o_busy;

    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    obs_t exp_q[$];
    obs_t last_obs = '0;
    obs_t last_exp = '0;

    // Reference model state
    bit m_run, m_done, m_pwm, m_irq;
    int m_cnt, sh_per, sh_duty;
    int in_per, in_duty;
    bit in_mode, in_cont;

    pwm_timer_core #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) dut (
        .i_wb_clk  (clk),
        .i_wb_rst_n(rst_n),
        .slow_clk  (slow_clk),
        .i_en      (i_en),
        .i_mode    (i_mode),
        .i_cont    (i_cont),
        .i_period  (i_period),
        .i_duty    (i_duty),
        .i_irq_clr (i_irq_clr),
        .o_cnt     (o_cnt),
        .o_pwm     (o_pwm),
        .o_irq     (o_irq),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    function automatic obs_t mk(input int cnt, input bit pwm, input bit irq, input bit busy);
        return {CNT_W'(cnt), pwm, irq, busy};
    endfunction

    // Monitor: every change of the observable outputs must match the next queued expectation
    always @(negedge clk) begin
        obs_t cur;
        obs_t e;
        cur = {o_cnt, o_pwm, o_irq, o_busy};
        if (mon_en && (cur !== last_obs)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got cnt=%0d pwm=%0b irq=%0b busy=%0b, required no change",
                         cur[CNT_W+2:3], cur[2], cur[1], cur[0]);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    errors++;
                    $display("FAIL output_seq: got cnt=%0d pwm=%0b irq=%0b busy=%0b, required cnt=%0d pwm=%0b irq=%0b busy=%0b",
                             cur[CNT_W+2:3], cur[2], cur[1], cur[0], e[CNT_W+2:3], e[2], e[1], e[0]);
                end
            end
        end
        last_obs = cur;
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    function automatic int act_per();
`ifdef PWM_SHADOW_REG_EN
        return sh_per;
`else
        return in_per;
`endif
    endfunction

    function automatic int act_duty();
`ifdef PWM_SHADOW_REG_EN
        return sh_duty;
`else
        return in_duty;
`endif
    endfunction

    task automatic push_exp();
        obs_t o;
        o = mk(m_cnt, m_pwm, m_irq, m_run);
        if (o != last_exp) begin
            exp_q.push_back(o);
            last_exp = o;
        end
    endtask

    task automatic pwm_refresh();
        if (m_run && in_mode) m_pwm = (act_per() != 0) && (m_cnt < act_duty());
    endtask

    task automatic model_tick(input bit clr_same_edge);
        bit ex;
        int p;
        ex = 1'b0;
        if (m_run) begin
            p = act_per();
            if (p == 0) begin
                m_cnt = 0;
            end else if (m_cnt + 1 >= p) begin
                ex    = 1'b1;
                m_irq = 1'b1;
                if (!in_mode) m_pwm = ~m_pwm;
                if (in_mode || in_cont) begin
                    m_cnt   = 0;
                    sh_per  = in_per;
                    sh_duty = in_duty;
                end else begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            pwm_refresh();
        end
        if (clr_same_edge && !ex) m_irq = 1'b0;
        push_exp();
    endtask

    task automatic pulse_slow();
        @(posedge clk); #1 slow_clk = 1'b1;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1 slow_clk = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_tick();
        model_tick(1'b0);
        pulse_slow();
    endtask

    // Clear pulse lands exactly on the edge where the tick is consumed
    task automatic race_tick();
        model_tick(1'b1);
        @(posedge clk); #1 slow_clk = 1'b1;
        repeat (SYNC_STAGES) @(posedge clk);
        #1 i_irq_clr = 1'b1;
        @(posedge clk); #1 i_irq_clr = 1'b0;
        @(posedge clk); #1 slow_clk = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic irq_clear();
        m_irq = 1'b0;
        push_exp();
        @(posedge clk); #1 i_irq_clr = 1'b1;
        @(posedge clk); #1 i_irq_clr = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic set_en(input bit v);
        if (!v) begin
            m_run = 1'b0; m_done = 1'b0; m_cnt = 0; m_pwm = 1'b0;
        end else if (!m_run && !m_done) begin
            m_run   = 1'b1;
            m_cnt   = 0;
            sh_per  = in_per;
            sh_duty = in_duty;
            m_pwm   = 1'b0;
            pwm_refresh();
        end
        push_exp();
        @(posedge clk); #1 i_en = v;
        repeat (2) @(posedge clk);
    endtask

    task automatic set_cfg(input bit mode, input bit cont, input int per, input int duty);
        in_mode = mode; in_cont = cont; in_per = per; in_duty = duty;
        @(posedge clk); #1;
        i_mode = mode; i_cont = cont; i_period = CNT_W'(per); i_duty = CNT_W'(duty);
        repeat (2) @(posedge clk);
    endtask

    task automatic write_period(input int per);
        in_per = per;
        if (m_run && act_per() == 0) m_cnt = 0;
        pwm_refresh();
        push_exp();
        @(posedge clk); #1 i_period = CNT_W'(per);
        repeat (2) @(posedge clk);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending changes, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", o_cnt, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_irq", o_irq, 0);
        chk("rst_pwm", o_pwm, 0);
        rst_n = 1'b1;

        // Asynchronous reset mid-period
        repeat (2) @(posedge clk);
        #1 i_mode = 1'b1; i_period = 16'd4; i_duty = 16'd1; i_en = 1'b1;
        repeat (2) @(posedge clk);
        pulse_slow();
        pulse_slow();
        #1;
        chk("pre_rst_cnt", o_cnt, 2);
        chk("pre_rst_busy", o_busy, 1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", o_cnt, 0);
        chk("async_rst_pwm", o_pwm, 0);
        chk("async_rst_irq", o_irq, 0);
        chk("async_rst_busy", o_busy, 0);
        i_en = 1'b0;
        #4 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", o_busy, 0);

        m_run = 0; m_done = 0; m_pwm = 0; m_irq = 0; m_cnt = 0;
        in_mode = 1'b1; in_cont = 1'b0; in_per = 4; in_duty = 1;
        sh_per = 0; sh_duty = 0;
        last_exp = '0;
        mon_en = 1'b1;
        pulse_slow();

        // PWM period 4 duty 1
        set_cfg(1'b1, 1'b0, 4, 1);
        set_en(1'b1);
        repeat (9) do_tick();
        drain("pwm_basic");
        set_en(1'b0);
        irq_clear();

        // duty >= period, duty 0, period 0
        set_cfg(1'b1, 1'b0, 3, 5);
        set_en(1'b1);
        repeat (5) do_tick();
        set_en(1'b0);
        set_cfg(1'b1, 1'b0, 4, 0);
        set_en(1'b1);
        repeat (5) do_tick();
        set_en(1'b0);
        irq_clear();
        set_cfg(1'b1, 1'b0, 0, 3);
        set_en(1'b1);
        repeat (4) do_tick();
        set_en(1'b0);
        drain("boundaries");

        // One-shot timer, then restart
        set_cfg(1'b0, 1'b0, 5, 0);
        set_en(1'b1);
        repeat (7) do_tick();
        drain("oneshot");
        chk("oneshot_cnt_hold", o_cnt, 4);
        set_en(1'b0);
        irq_clear();
        set_en(1'b1);
        repeat (2) do_tick();
        set_en(1'b0);
        drain("oneshot_restart");

        // IRQ clear racing the expiry
        irq_clear();
        set_cfg(1'b1, 1'b0, 2, 1);
        set_en(1'b1);
        do_tick();
        race_tick();
        irq_clear();
        set_en(1'b0);
        drain("irq_race");

        // Live period change from 8 to 3 at cnt 5
        set_cfg(1'b1, 1'b0, 8, 2);
        set_en(1'b1);
        repeat (5) do_tick();
        write_period(3);
        repeat (10) do_tick();
        set_en(1'b0);
        irq_clear();
        drain("period_change");

        // Randomised configurations
        for (int it = 0; it < 25; it++) begin
            set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
            set_en(1'b1);
            for (int t = int'($urandom_range(1, 12)); t > 0; t--) begin
                if ($urandom_range(0, 5) == 0) race_tick();
                else do_tick();
                if ($urandom_range(0, 7) == 0) irq_clear();
            end
            set_en(1'b0);
            drain("random");
        end

        repeat (10) @(posedge clk);
        drain("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_timer_core.md
# pwm_timer_core

Counting stage directly downstream of the clock divider. It takes the divided `slow_clk` into the bus clock domain and turns each rising edge into a one-cycle tick. It counts ticks against programmed period and duty values. It produces either a PWM waveform or a periodic/one-shot timer expiry, plus a sticky interrupt flag read through the register file.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchroniser flops on `slow_clk`; legal range 2–4.
- `CNT_W`, default 16: width of the counter, period and duty.

Ports:
- `i_wb_clk` in 1: bus clock; all state is on its rising edge.
- `i_wb_rst_n` in 1: reset, asynchronous, active-low.
- `slow_clk` in 1: divided clock from the divider; treated as asynchronous.
- `i_en` in 1: core enable.
- `i_mode` in 1: 0 = timer, 1 = PWM.
- `i_cont` in 1: timer mode only; 1 = continuous, 0 = one-shot.
- `i_period` in CNT_W: ticks per period.
- `i_duty` in CNT_W: high ticks per period (PWM mode).
- `i_irq_clr` in 1: one-cycle pulse that clears `o_irq`.
- `o_cnt` out CNT_W: current tick count.
- `o_pwm` out 1: PWM output, or timer toggle output.
- `o_irq` out 1: sticky expiry flag.
- `o_busy` out 1: high while in RUN.

## Operation
- Synchroniser and edge detect: `slow_clk` passes through SYNC_STAGES flops, then one history flop. `tick` = last sync stage & ~history.
  - `slow_clk` high and low phases must each be at least 2 `i_wb_clk` periods. Faster input gives undefined tick counts.
- States:
  - IDLE: `o_cnt`=0, `o_pwm`=0, `o_busy`=0. `i_en`=1 → RUN; load the active period/duty and set `cnt`=0.
  - RUN: on `tick`, if `cnt` >= `period_act`−1 it is an expiry, otherwise `cnt`+1.
    - PWM mode expiry: `cnt`←0, set `o_irq`.
    - Timer mode expiry: set `o_irq`, toggle `o_pwm`. If `i_cont`=1, `cnt`←0; otherwise → DONE and `cnt` holds.
  - DONE: `o_busy`=0, `cnt` and `o_pwm` hold. `i_en`=0 → IDLE.
  - `i_en`=0 in any state → IDLE on the next edge, clearing `cnt` and `o_pwm`.
- The compare uses >=, so a live period decrease below the current `cnt` expires on the next tick.
- `period_act`=0: `cnt` stays 0, no expiry, no irq, `o_pwm`=0.
- PWM output: `o_pwm`=1 exactly while `o_cnt` < `duty_act`, registered so it changes on the same edge as `o_cnt`.
  - `duty_act`=0 gives a constant 0.
  - `duty_act` >= `period_act` gives a constant 1 while in RUN.
- Mode changes are legal only while `i_en`=0; otherwise behaviour is undefined.
- `o_irq` is set by expiry and cleared by `i_irq_clr`. Set wins if both occur in the same cycle. It is unaffected by `i_en`.

## Timing
- Reset values: `o_cnt`=0, `o_pwm`=0, `o_irq`=0, `o_busy`=0, state IDLE, synchroniser and history flops 0.
- `slow_clk` rise → `o_cnt` update: SYNC_STAGES+1 `i_wb_clk` edges, +1 depending on sampling phase.
- `i_en` rise → `o_busy`=1 at the next edge. Counting starts at the first tick after that.
- Expiry → `o_irq` rises on the same edge that wraps or stops `cnt`.
- `i_irq_clr` → `o_irq` low at the next edge.
- Reset assertion mid-RUN forces all outputs to their reset values immediately, without waiting for a clock.

## Configuration
- `PWM_SHADOW_REG_EN` defined:
  - `period_act`/`duty_act` are shadow copies of `i_period`/`i_duty`.
  - Copies are loaded on IDLE→RUN and at every expiry that wraps.
  - Mid-period writes take effect at the next period boundary, giving glitch-free PWM.
- Not defined: `period_act`/`duty_act` are `i_period`/`i_duty` used live every cycle.

## Test plan
- Reset: run PWM with period=4, then pulse `i_wb_rst_n` low mid-period → all outputs 0 with no clock edge. After release, state is IDLE.
- PWM: period=4, duty=1, `slow_clk` = `i_wb_clk`/8 → `o_pwm` high for 1 tick of every 4, `o_cnt` cycles 0,1,2,3, and `o_irq` is set at the first wrap.
- Boundaries:
  - duty=5, period=3 → `o_pwm` constant 1.
  - duty=0 → constant 0.
  - period=0 → `o_cnt` stays 0 and `o_irq` never sets.
- One-shot timer: period=5, `i_cont`=0 → after the 5th tick `o_irq`=1, `o_busy`=0, `o_cnt` holds 4, `o_pwm` toggles once. Toggle `i_en` 0→1 → restarts from 0.
- IRQ race: assert `i_irq_clr` on the expiry cycle → `o_irq` stays 1. A clear on the next cycle drops it.
- Period change: PWM period=8; write 3 when `o_cnt`=5.
  - With `PWM_SHADOW_REG_EN`: the current period completes at 8 ticks, then periods are 3.
  - Without: expiry on the next tick, then periods are 3.
